// File: rtl/reg_file_wb_if.sv
// Register-file bus: two ID read ports with busy flags, scoreboard set port,
// WB write port and the scoreboard summary flag.
interface reg_file_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] reg_read_addr_1;
    logic [ADDR_W-1:0] reg_read_addr_2;
    logic [DATA_W-1:0] reg_read_data_1;
    logic [DATA_W-1:0] reg_read_data_2;
    logic              reg_read_busy_1;
    logic              reg_read_busy_2;
    logic              busy_set_en;
    logic [ADDR_W-1:0] busy_set_addr;
    logic              reg_write_en;
    logic [ADDR_W-1:0] reg_write_addr;
    logic [DATA_W-1:0] reg_write_data;
    logic              busy_any;

    modport master (
        output reg_read_addr_1, reg_read_addr_2,
        output busy_set_en, busy_set_addr,
        output reg_write_en, reg_write_addr, reg_write_data,
        input  reg_read_data_1, reg_read_data_2,
        input  reg_read_busy_1, reg_read_busy_2, busy_any
    );

    modport slave (
        input  reg_read_addr_1, reg_read_addr_2,
        input  busy_set_en, busy_set_addr,
        input  reg_write_en, reg_write_addr, reg_write_data,
        output reg_read_data_1, reg_read_data_2,
        output reg_read_busy_1, reg_read_busy_2, busy_any
    );
endinterface

// File: rtl/reg_file_wb.sv
// MIPS 32x32 register file with one WB write port, two combinational read
// ports and a pending-write scoreboard. Define REG_FILE_WB_BYPASS_EN for WB->ID bypass.
module reg_file_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_wb_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic              w_wr_valid;
    logic [DATA_W-1:0] w_rd_data_1;
    logic [DATA_W-1:0] w_rd_data_2;
    logic              w_rd_busy_1;
    logic              w_rd_busy_2;

    assign w_wr_valid = bus.reg_write_en && (bus.reg_write_addr != '0);

    // Set is applied after clear so a younger producer's claim wins a collision.
    always_comb begin
        w_busy_nxt = r_busy;
        if (bus.reg_write_en)
            w_busy_nxt[bus.reg_write_addr] = 1'b0;
        if (bus.busy_set_en)
            w_busy_nxt[bus.busy_set_addr] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
            r_busy <= '0;
        end else begin
            if (w_wr_valid)
                r_mem[bus.reg_write_addr] <= bus.reg_write_data;
            r_busy <= w_busy_nxt;
        end
    end

    always_comb begin
        w_rd_data_1 = (bus.reg_read_addr_1 == '0) ? '0 : r_mem[bus.reg_read_addr_1];
        w_rd_busy_1 = r_busy[bus.reg_read_addr_1];
        w_rd_data_2 = (bus.reg_read_addr_2 == '0) ? '0 : r_mem[bus.reg_read_addr_2];
        w_rd_busy_2 = r_busy[bus.reg_read_addr_2];
`ifdef REG_FILE_WB_BYPASS_EN
        // Forward the WB result; busy stays up only if a new producer claims it now.
        if (w_wr_valid && (bus.reg_write_addr == bus.reg_read_addr_1)) begin
            w_rd_data_1 = bus.reg_write_data;
            w_rd_busy_1 = bus.busy_set_en && (bus.busy_set_addr == bus.reg_read_addr_1);
        end
        if (w_wr_valid && (bus.reg_write_addr == bus.reg_read_addr_2)) begin
            w_rd_data_2 = bus.reg_write_data;
            w_rd_busy_2 = bus.busy_set_en && (bus.busy_set_addr == bus.reg_read_addr_2);
        end
`endif
    end

    assign bus.reg_read_data_1 = w_rd_data_1;
    assign bus.reg_read_data_2 = w_rd_data_2;
    assign bus.reg_read_busy_1 = w_rd_busy_1;
    assign bus.reg_read_busy_2 = w_rd_busy_2;
    assign bus.busy_any        = |r_busy;
endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- 32x32 MIPS general-purpose register file with one write-back port and two combinational read ports.
- Read ports drive the ID-stage operand buses reg_read_data_1 and reg_read_data_2. These feed the branch equality comparator and the ID/EX register.
- Holds a per-register pending-write scoreboard, so ID can stall a branch compare or operand read until the producing instruction has written back.
- Sits between the WB stage (writer) and the ID stage (reader).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- reg_read_addr_1  in  ADDR_W  read port 1 address (rs).
- reg_read_addr_2  in  ADDR_W  read port 2 address (rt).
- reg_read_data_1  out  DATA_W  read port 1 data.
- reg_read_data_2  out  DATA_W  read port 2 data.
- reg_read_busy_1  out  1  register at port 1 has a write-back outstanding.
- reg_read_busy_2  out  1  register at port 2 has a write-back outstanding.
- busy_set_en  in  1  ID issued an instruction that will write busy_set_addr.
- busy_set_addr  in  ADDR_W  destination register of the issued instruction.
- reg_write_en  in  1  WB-stage write strobe.
- reg_write_addr  in  ADDR_W  WB destination register.
- reg_write_data  in  DATA_W  WB result.
- busy_any  out  1  OR of all scoreboard bits; used by drain/flush logic.

Behaviour:
- Reset (async, immediate on rst=1): all 32 registers = 0 and all busy bits = 0. Outputs follow combinationally: data 0, busy 0, busy_any 0.
- Reads are combinational from addr to data and busy, with zero-cycle latency.
- Register 0:
  - reads always return 0 and busy 0;
  - writes to addr 0 are ignored;
  - busy_set to addr 0 is ignored.
- Write: on a rising edge with reg_write_en=1 and addr≠0, mem[addr] <= reg_write_data. The new value is visible on read ports from the following cycle; same-cycle visibility depends on the optional feature.
- Scoreboard, per register r≠0, evaluated at each rising edge:
  - set only (busy_set_en and busy_set_addr==r) -> busy[r] <= 1.
  - clear only (reg_write_en and reg_write_addr==r) -> busy[r] <= 0.
  - set and clear in the same cycle on the same r -> busy[r] <= 1. The set wins because it belongs to a younger producer.
  - neither -> hold.
- A write to a register whose busy bit is 0 is legal: it updates data and busy stays 0.
- A busy_set on an already-busy register keeps it at 1. There is no counting; one outstanding producer per register is tracked.
- Both read ports may address the same register; both return identical data and busy.
- rst asserted mid-cycle, including during a write strobe, discards that write. State is all-zero while rst=1. The first update occurs on the first rising edge after rst deasserts.

Optional Feature:
- Macro: REG_FILE_WB_BYPASS_EN.
- Defined: same-cycle write-to-read bypass. If reg_write_en=1, reg_write_addr==read addr, and addr≠0, then:
  - reg_read_data_n = reg_write_data combinationally in that cycle;
  - reg_read_busy_n = 0 in that cycle, unless busy_set_en targets the same addr in that cycle.
  - This removes one stall cycle for a branch dependent on a WB result.
- Undefined: the read port returns the stored value and stored busy bit. The written value and the cleared busy bit appear one cycle later.

Test Plan:
- Reset: pulse rst mid-cycle after writing 32'h1234_5678 to r5 -> r5 reads 0 immediately, and busy_any=0.
- Write/read: write 32'hAAAA_AAAA to r3, then read port1=r3 and port2=r3 the next cycle -> both 32'hAAAA_AAAA, busy 0.
- Zero register: write 32'hFFFF_FFFF to r0 and busy_set r0 -> r0 reads 0, busy 0, busy_any 0.
- Scoreboard: busy_set r7 -> reg_read_busy_1=1 for addr 7. Two cycles later, write 32'h5A3C_B2F1 to r7 -> busy 0 next cycle, data 32'h5A3C_B2F1.
- Set/clear collision: r9 busy; in one cycle, write r9 = 32'hA5C3_4D0E and busy_set r9 -> next cycle data = 32'hA5C3_4D0E and busy = 1.
- Bypass: write r4 = 32'h0000_00FF while port2 reads r4.
  - With REG_FILE_WB_BYPASS_EN: same cycle shows 32'h0000_00FF, busy 0.
  - Without it: old value in that cycle, new value the next cycle.
